writeback_stage: RTL and testbench

Final pipeline stage of the RISC pipeline. It registers the execute-stage result and sequences data-memory loads. It drives the register-file write port and publishes the writeback-side forwarding signals: valid, write enable, destination and result. It also stalls the upstream pipeline while a load is outstanding, so the forwarding unit never bypasses stale load data.

---
 rtl/writeback_stage.sv | 100 ++++++++++
 tb/tb_writeback_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: registers the execute result, sequences data-memory loads,
// and drives the register-file write port plus the writeback forwarding signals.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// RUN       | capture ex_* every edge; ALU results write back after one cycle
// LOAD_WAIT | load outstanding; pipeline stalled until mem_rvalid or timeout
module writeback_stage #(
    parameter int A_SIZE  = 10,
    parameter int D_SIZE  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_write,
    input  logic              ex_is_load,
    input  logic [2:0]        ex_dest,
    input  logic [D_SIZE-1:0] ex_result,
    input  logic [A_SIZE-1:0] ex_addr,
    output logic              mem_read,
    output logic [A_SIZE-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [D_SIZE-1:0] mem_rdata,
    output logic              reset_wb,
    output logic              write_en,
    output logic [2:0]        dest_wb,
    output logic [D_SIZE-1:0] result_wb,
    output logic              stall,
    output logic              load_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic            ex_load;

    assign ex_load = ex_valid & ex_write & ex_is_load;

    // Stall comes straight from state so the upstream freeze starts the
    // cycle right after a load is captured.
    assign stall = (state == LOAD_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
            reset_wb  <= 1'b0;
            write_en  <= 1'b0;
            dest_wb   <= '0;
            result_wb <= '0;
            load_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    reset_wb <= ex_valid;
                    dest_wb  <= ex_dest;
                    if (ex_load) begin
                        write_en <= 1'b0;
                        mem_addr <= ex_addr;
                        mem_read <= 1'b1;
                        wait_cnt <= '0;
                        state    <= LOAD_WAIT;
                    end else begin
                        write_en  <= ex_valid & ex_write;
                        result_wb <= ex_result;
                    end
                end
                LOAD_WAIT: begin
                    if (mem_rvalid) begin
                        result_wb <= mem_rdata;
                        write_en  <= 1'b1;
                        mem_read  <= 1'b0;
                        state     <= RUN;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Drop the load: nothing is written and the slot retires.
                        load_err <= 1'b1;
                        mem_read <= 1'b0;
                        write_en <= 1'b0;
                        reset_wb <= 1'b0;
                        state    <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: vector table for ALU/bubble traffic
// and hand sequences for loads, timeout and asynchronous reset.
module tb_writeback_stage;

    localparam int A_SIZE  = 10;
    localparam int D_SIZE  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid, ex_write, ex_is_load;
    logic [2:0]        ex_dest;
    logic [D_SIZE-1:0] ex_result;
    logic [A_SIZE-1:0] ex_addr;
    logic              mem_read;
    logic [A_SIZE-1:0] mem_addr;
    logic              mem_rvalid;
    logic [D_SIZE-1:0] mem_rdata;
    logic              reset_wb, write_en, stall, load_err;
    logic [2:0]        dest_wb;
    logic [D_SIZE-1:0] result_wb;

    writeback_stage #(.A_SIZE(A_SIZE), .D_SIZE(D_SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_write(ex_write), .ex_is_load(ex_is_load),
        .ex_dest(ex_dest), .ex_result(ex_result), .ex_addr(ex_addr),
        .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .reset_wb(reset_wb), .write_en(write_en), .dest_wb(dest_wb),
        .result_wb(result_wb), .stall(stall), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rwb, we;
        logic [2:0]        dest;
        logic              res_chk;
        logic [D_SIZE-1:0] res;
        logic              stl, mrd;
        logic              addr_chk;
        logic [A_SIZE-1:0] addr;
        logic              err;
    } exp_t;

    typedef struct {
        logic              v, w, l;
        logic [2:0]        d;
        logic [D_SIZE-1:0] r;
        logic              e_rwb, e_we;
    } vec_t;

    exp_t  sb_q[$];
    vec_t  vecs[8];
    int    errors = 0;
    int    checks = 0;

    function automatic exp_t mk(logic rwb, logic we, logic [2:0] dest, logic res_chk,
                                logic [D_SIZE-1:0] res, logic stl, logic mrd,
                                logic addr_chk, logic [A_SIZE-1:0] addr, logic err);
        exp_t e;
        e.rwb = rwb; e.we = we; e.dest = dest; e.res_chk = res_chk; e.res = res;
        e.stl = stl; e.mrd = mrd; e.addr_chk = addr_chk; e.addr = addr; e.err = err;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry (t=%0t)", $time);
        end else begin
            e = sb_q.pop_front();
            chk("reset_wb", 64'(reset_wb), 64'(e.rwb));
            chk("write_en", 64'(write_en), 64'(e.we));
            chk("dest_wb",  64'(dest_wb),  64'(e.dest));
            chk("stall",    64'(stall),    64'(e.stl));
            chk("mem_read", 64'(mem_read), 64'(e.mrd));
            chk("load_err", 64'(load_err), 64'(e.err));
            if (e.res_chk)  chk("result_wb", 64'(result_wb), 64'(e.res));
            if (e.addr_chk) chk("mem_addr",  64'(mem_addr),  64'(e.addr));
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic l, input logic [2:0] d,
                         input logic [D_SIZE-1:0] r, input logic [A_SIZE-1:0] a);
        ex_valid = v; ex_write = w; ex_is_load = l;
        ex_dest = d; ex_result = r; ex_addr = a;
    endtask

    // Push the expectation for the coming edge, then compare just after it.
    task automatic step(input exp_t e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{v:1, w:1, l:0, d:3, r:32'h0000_00A5, e_rwb:1, e_we:1};
        vecs[1] = '{v:1, w:0, l:0, d:1, r:32'h0000_0011, e_rwb:1, e_we:0};
        vecs[2] = '{v:0, w:1, l:0, d:6, r:32'h0000_0022, e_rwb:0, e_we:0};
        vecs[3] = '{v:1, w:1, l:0, d:7, r:32'hFFFF_FFFF, e_rwb:1, e_we:1};
        vecs[4] = '{v:1, w:1, l:0, d:0, r:32'h0000_0000, e_rwb:1, e_we:1};
        vecs[5] = '{v:0, w:0, l:0, d:2, r:32'h5555_AAAA, e_rwb:0, e_we:0};
        vecs[6] = '{v:1, w:0, l:1, d:4, r:32'h1357_9BDF, e_rwb:1, e_we:0};
        vecs[7] = '{v:0, w:1, l:1, d:5, r:32'h2468_ACE0, e_rwb:0, e_we:0};

        rst = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        drive(0, 0, 0, 0, '0, '0);
        #12;
        sb_q.push_back(mk(0, 0, 0, 1, '0, 0, 0, 1, '0, 0));
        compare_front();
        @(negedge clk);
        rst = 1'b1;

        // ALU / bubble table, back to back with no gaps
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].w, vecs[i].l, vecs[i].d, vecs[i].r, 10'h000);
            step(mk(vecs[i].e_rwb, vecs[i].e_we, vecs[i].d, 1, vecs[i].r, 0, 0, 0, '0, 0));
        end

        // Load with 3-cycle memory, ALU held on ex_* during the stall
        @(negedge clk);
        drive(1, 1, 1, 5, 32'h0BAD_0BAD, 10'h040);
        step(mk(1, 0, 5, 0, '0, 1, 1, 1, 10'h040, 0));
        @(negedge clk);
        drive(1, 1, 0, 2, 32'h1234_5678, 10'h3C3);
        step(mk(1, 0, 5, 0, '0, 1, 1, 1, 10'h040, 0));
        step(mk(1, 0, 5, 0, '0, 1, 1, 1, 10'h040, 0));
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step(mk(1, 1, 5, 1, 32'hDEAD_BEEF, 0, 0, 0, '0, 0));
        @(negedge clk);
        mem_rvalid = 1'b0;
        step(mk(1, 1, 2, 1, 32'h1234_5678, 0, 0, 0, '0, 0));

        // Back-to-back loads, each answered after one cycle
        @(negedge clk);
        drive(1, 1, 1, 1, '0, 10'h0AA);
        step(mk(1, 0, 1, 0, '0, 1, 1, 1, 10'h0AA, 0));
        @(negedge clk);
        drive(1, 1, 1, 4, '0, 10'h0BB);
        mem_rvalid = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        step(mk(1, 1, 1, 1, 32'h0BAD_F00D, 0, 0, 0, '0, 0));
        @(negedge clk);
        mem_rvalid = 1'b0;
        step(mk(1, 0, 4, 0, '0, 1, 1, 1, 10'h0BB, 0));
        @(negedge clk);
        drive(0, 0, 0, 0, '0, '0);
        mem_rvalid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        step(mk(1, 1, 4, 1, 32'hCAFE_F00D, 0, 0, 0, '0, 0));
        @(negedge clk);
        mem_rvalid = 1'b0;
        step(mk(0, 0, 0, 1, '0, 0, 0, 0, '0, 0));

        // Timeout: no response ever arrives
        @(negedge clk);
        drive(1, 1, 1, 6, '0, 10'h3FF);
        step(mk(1, 0, 6, 0, '0, 1, 1, 1, 10'h3FF, 0));
        @(negedge clk);
        drive(0, 0, 0, 6, '0, '0);
        for (int i = 1; i < TIMEOUT; i++)
            step(mk(1, 0, 6, 0, '0, 1, 1, 1, 10'h3FF, 0));
        step(mk(0, 0, 6, 0, '0, 0, 0, 0, '0, 1));
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata = 32'hBBBB_BBBB;
        step(mk(0, 0, 6, 1, '0, 0, 0, 0, '0, 1));
        @(negedge clk);
        mem_rvalid = 1'b0;

        // Asynchronous reset while a load is outstanding
        drive(1, 1, 1, 2, '0, 10'h155);
        step(mk(1, 0, 2, 0, '0, 1, 1, 1, 10'h155, 1));
        #1;
        rst = 1'b0;
        #1;
        sb_q.push_back(mk(0, 0, 0, 1, '0, 0, 0, 1, '0, 0));
        compare_front();
        @(negedge clk);
        drive(0, 0, 0, 0, '0, '0);
        mem_rvalid = 1'b1;
        mem_rdata = 32'h7777_7777;
        @(negedge clk);
        rst = 1'b1;
        step(mk(0, 0, 0, 1, '0, 0, 0, 1, '0, 0));
        @(negedge clk);
        mem_rvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
